ntt_bfly_scheduler: RTL and testbench

NTT_BFLY_SCHEDULER -- requirements
Module: ntt_bfly_scheduler

---
 rtl/ntt_bfly_scheduler.sv | 151 +++++++++++++++
 tb/tb_ntt_bfly_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfly_scheduler.sv
// ntt_bfly_scheduler
//   Address/twiddle sequencer for an in-place radix-2 NTT over N = 2**LOG_N
//   coefficients. Walks LOG_N stages of N/2 butterflies each and presents one
//   butterfly per cycle under a valid/ready handshake.
//
//   Forward (mode 0, Cooley-Tukey):    len = N >> (s+1), zeta = N/(2*len) + g
//   Inverse (mode 1, Gentleman-Sande): len = 1 << s,     zeta = N/len - 1 - g,
//                                      negated twiddle
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, mode_i       launch a transform (sampled in IDLE only), direction
//   ready_i               downstream accepts the presented pair
//   valid_o               a butterfly is being presented
//   addr1_o, addr2_o      upper/lower coefficient addresses (addr2 = addr1 + len)
//   zeta_idx_o, zeta_neg_o twiddle ROM index and negate flag
//   is_GS_BU_o            butterfly type (latched mode)
//   stage_o               current stage
//   last_o                presented pair is the final butterfly
//   busy_o, done_o        running / one-cycle completion pulse
//
// Every output is decoded from registered state; ready_i and start_i only
// reach the next-state logic.
module ntt_bfly_scheduler #(
  parameter int LOG_N  = 8,
  parameter int ADDR_W = LOG_N
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic [ADDR_W-1:0] zeta_idx_o,
  output logic              zeta_neg_o,
  output logic              is_GS_BU_o,
  output logic [2:0]        stage_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int N  = 1 << LOG_N;
  localparam int BW = LOG_N - 1;   // butterfly counter covers 0..N/2-1

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      s_q, s_d;       // stage_o is 3 bits, so LOG_N <= 8
  logic [BW-1:0]   b_q, b_d;
  logic            mode_q, mode_d;

  logic            run, b_end, s_end, last_pair;

  assign run       = (state_q == RUN);
  assign b_end     = &b_q;
  assign s_end     = (s_q == 3'(LOG_N - 1));
  assign last_pair = b_end && s_end;

  // ---------------------------------------------------------------------------
  // Address / twiddle decode. lgl = log2(len); len is a power of two, so the
  // group/offset split of b is a shift and a mask.
  // ---------------------------------------------------------------------------
  logic [2:0]        lgl;
  logic [ADDR_W-1:0] b_ext, len, grp, off, a1, zeta;
  logic [ADDR_W:0]   n_over_l;     // N/len needs one extra bit when len = 1

  always_comb begin
    lgl      = mode_q ? s_q : (3'(LOG_N - 1) - s_q);
    b_ext    = ADDR_W'(b_q);
    len      = ADDR_W'(1) << lgl;
    grp      = b_ext >> lgl;
    off      = b_ext & (len - ADDR_W'(1));
    // Two shifts instead of (lgl+1): lgl+1 wraps in 3 bits when lgl = 7.
    a1       = ((grp << lgl) << 1) | off;
    n_over_l = (ADDR_W + 1)'(N) >> lgl;
    if (mode_q)
      zeta = ADDR_W'(n_over_l - (ADDR_W + 1)'(1) - {1'b0, grp});
    else
      // N/(2*len) = 2**s in forward mode.
      zeta = (ADDR_W'(1) << s_q) + grp;
  end

  // ---------------------------------------------------------------------------
  // FSM + counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mode_d  = mode_i;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (last_pair) begin
            state_d = DONE;
            s_d     = '0;
            b_d     = '0;
          end else if (b_end) begin
            b_d = '0;
            s_d = s_q + 3'd1;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: addressing is forced to zero outside RUN so idle/reset values are
  // clean rather than the stage-0 decode.
  // ---------------------------------------------------------------------------
  assign valid_o    = run;
  assign addr1_o    = run ? a1 : '0;
  assign addr2_o    = run ? (a1 + len) : '0;
  assign zeta_idx_o = run ? zeta : '0;
  assign zeta_neg_o = run && mode_q;
  assign is_GS_BU_o = mode_q;
  assign stage_o    = run ? s_q : '0;
  assign last_o     = run && last_pair;
  assign busy_o     = run;
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_ntt_bfly_scheduler.sv
module tb_ntt_bfly_scheduler;

  localparam int LOG_N = 8;
  localparam int N     = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, mode_i = 1'b0, ready_i = 1'b1;
  logic       valid_o, zeta_neg_o, is_GS_BU_o, last_o, busy_o, done_o;
  logic [7:0] addr1_o, addr2_o, zeta_idx_o;
  logic [2:0] stage_o;

  ntt_bfly_scheduler #(.LOG_N(LOG_N), .ADDR_W(LOG_N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .mode_i(mode_i),
    .ready_i(ready_i), .valid_o(valid_o), .addr1_o(addr1_o),
    .addr2_o(addr2_o), .zeta_idx_o(zeta_idx_o), .zeta_neg_o(zeta_neg_o),
    .is_GS_BU_o(is_GS_BU_o), .stage_o(stage_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] z;
    logic       neg;
    logic       gs;
    logic [2:0] stg;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  bit   last_prev = 0;
  exp_t last_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence from the textbook triple loop (len / group start / j).
  task automatic push_model(input bit inv);
    exp_t e;
    int   k;
    int   stg = 0;
    if (!inv) begin
      k = 1;
      for (int len = N/2; len >= 1; len = len >> 1) begin
        for (int st = 0; st < N; st += 2*len) begin
          for (int j = st; j < st + len; j++) begin
            e = '{a1: 8'(j), a2: 8'(j+len), z: 8'(k), neg: 1'b0, gs: 1'b0,
                  stg: 3'(stg), last: 1'b0};
            exp_q.push_back(e);
          end
          k++;
        end
        stg++;
      end
    end else begin
      for (int len = 1; len <= N/2; len = len << 1) begin
        k = N/len - 1;
        for (int st = 0; st < N; st += 2*len) begin
          for (int j = st; j < st + len; j++) begin
            e = '{a1: 8'(j), a2: 8'(j+len), z: 8'(k), neg: 1'b1, gs: 1'b1,
                  stg: 3'(stg), last: 1'b0};
            exp_q.push_back(e);
          end
          k--;
        end
        stg++;
      end
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // Monitor: every transfer pops one expected pair; done must follow the
  // last transfer by exactly one cycle.
  always @(negedge clk) begin
    exp_t got, e;
    bit   xfer;
    if (rst) begin
      last_prev = 0;
    end else begin
      chk("done_timing", 32'(done_o), 32'(last_prev));
      xfer = valid_o && ready_i;
      if (xfer) begin
        got = '{a1: addr1_o, a2: addr2_o, z: zeta_idx_o, neg: zeta_neg_o,
                gs: is_GS_BU_o, stg: stage_o, last: last_o};
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(got), 32'h0);
          chk("unexpected_xfer_flag", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pair", 32'(got), 32'(e));
        end
        xfer_cnt++;
        if (last_o) last_seen = got;
      end
      last_prev = xfer && last_o;
    end
  end

  task automatic do_start(input bit m);
    xfer_cnt = 0;
    push_model(m);
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = m;
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic chk_first(input bit inv);
    chk("first_valid", 32'(valid_o), 32'd1);
    chk("first_addr1", 32'(addr1_o), 32'd0);
    chk("first_addr2", 32'(addr2_o), inv ? 32'd1 : 32'd128);
    chk("first_zeta",  32'(zeta_idx_o), inv ? 32'd255 : 32'd1);
    chk("first_neg",   32'(zeta_neg_o), 32'(inv));
    chk("first_gs",    32'(is_GS_BU_o), 32'(inv));
  endtask

  task automatic run_to_done(input bit stall_en, input bit ign_en);
    int stall_left = 0;
    bit stalled    = 0;
    bit finished   = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start_i = 1'b0; mode_i = 1'b0;
      if (done_o) begin
        finished = 1;
        chk("done_busy_low",  32'(busy_o), 32'd0);
        chk("done_valid_low", 32'(valid_o), 32'd0);
        chk("xfer_count", 32'(xfer_cnt), 32'd1024);
        // start in DONE must be ignored
        start_i = 1'b1; mode_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; mode_i = 1'b0;
        chk("start_in_done_ignored", 32'(valid_o), 32'd0);
        chk("idle_done_low", 32'(done_o), 32'd0);
      end else begin
        if (stall_en && !stalled && valid_o && stage_o == 3'd2 && addr1_o == 8'd128) begin
          ready_i = 1'b0; stall_left = 5; stalled = 1;
        end else if (stall_left > 0) begin
          chk("stall_addr1", 32'(addr1_o), 32'd128);
          chk("stall_addr2", 32'(addr2_o), 32'd160);
          chk("stall_zeta",  32'(zeta_idx_o), 32'd6);
          chk("stall_valid", 32'(valid_o), 32'd1);
          stall_left--;
          if (stall_left == 0) ready_i = 1'b1;
        end
        if (ign_en && cyc == 300) begin
          start_i = 1'b1; mode_i = 1'b1;
        end
      end
    end
    if (!finished) chk("done_timeout", 32'd0, 32'd1);
    if (stall_en) chk("stall_seen", 32'(stalled), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_addrs", {addr1_o, addr2_o, zeta_idx_o, 8'(stage_o)}, 32'd0);
    chk("rst_flags", {28'd0, last_o, zeta_neg_o, is_GS_BU_o, 1'b0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(valid_o), 32'd0);

    // Forward with a stall at stage 2 b=64 and a stray inverse start mid-run
    do_start(1'b0);
    chk_first(1'b0);
    run_to_done(1'b1, 1'b1);
    chk("fwd_last", 32'(last_seen), 32'({8'd254, 8'd255, 8'd255, 1'b0, 1'b0, 3'd7, 1'b1}));

    // Inverse
    do_start(1'b1);
    chk_first(1'b1);
    run_to_done(1'b0, 1'b0);
    chk("inv_last", 32'(last_seen), 32'({8'd127, 8'd255, 8'd1, 1'b1, 1'b1, 3'd7, 1'b1}));

    // Asynchronous reset mid-transform
    do_start(1'b0);
    begin
      bit hit = 0;
      for (int c = 0; c < 2000 && !hit; c++) begin
        @(posedge clk); #1;
        if (stage_o == 3'd3) hit = 1;
      end
      chk("reach_stage3", 32'(hit), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_busy",  32'(busy_o), 32'd0);
    chk("abort_done",  32'(done_o), 32'd0);
    chk("abort_stage", 32'(stage_o), 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_abort_done", 32'(done_o), 32'd0);
      chk("post_abort_valid", 32'(valid_o), 32'd0);
    end
    do_start(1'b0);
    chk_first(1'b0);
    run_to_done(1'b0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
